// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the ST7735 SPI byte writer.
package lcd_pkg;

  // Value of the dc bit (data[8] / lcd_dc) for command and data bytes.
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // ST7735 opcodes used when setting up a drawing window.
  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  // One-hot writer states.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_DONE  = 4'b0100,
    ST_GAP   = 4'b1000
  } lcd_state_t;

endpackage

// File: rtl/lcd_spi_byte_writer_if.sv
// Producer-side handshake of the byte writer.
// Handshake: en_write is a level request and data must be valid while it is
// high; the writer samples both only while idle. wr_done pulses for exactly
// one cycle when the byte has been shifted out; the producer may then change
// data, which is not sampled again until the inter-byte gap has elapsed.
// busy is high whenever the writer is not idle. state mirrors the FSM.
interface lcd_spi_byte_writer_if;
  import lcd_pkg::*;

  logic       en_write;
  logic [8:0] data;
  logic       wr_done;
  logic       busy;
  lcd_state_t state;

  modport master (output en_write, output data, input wr_done, input busy, input state);
  modport slave  (input en_write, input data, output wr_done, output busy, output state);
endinterface

// File: rtl/lcd_spi_clkgen.sv
// SCK divider: counts sys_clk cycles per SCK half-period while enabled and
// flags whether the coming SCK toggle is a rising or a falling one.
module lcd_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int            DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick     = en && (div_cnt == DIV_LAST);
  assign sck_rise = tick && !sck;
  assign sck_fall = tick && sck;

  // Half-period counter; held at zero whenever the writer is not shifting.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/lcd_spi_byte_writer.sv
// Serialises one 9-bit {dc, byte} LCD word per CS-low frame on 4-wire SPI,
// mode 0, MSB first. All pin outputs are registered.
module lcd_spi_byte_writer
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  lcd_spi_byte_writer_if.slave        bus,
  output logic                        lcd_cs,
  output logic                        lcd_sck,
  output logic                        lcd_mosi,
  output logic                        lcd_dc
);

  localparam int            GW       = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    BIT_LAST = 3'd7;

  lcd_state_t    state, state_d;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          wr_done_r;
  logic          busy_r;
  logic          sck_rise;
  logic          sck_fall;

  assign bus.wr_done = wr_done_r;
  assign bus.busy    = busy_r;
  assign bus.state   = state;

  lcd_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (state == ST_SHIFT),
    .sck      (lcd_sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state: a frame always runs to completion once started.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (bus.en_write) state_d = ST_SHIFT;
      ST_SHIFT: if (sck_fall && (bit_cnt == BIT_LAST)) state_d = ST_DONE;
      ST_DONE:  state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and pin registers; MOSI only changes on falling SCK toggles so
  // it is stable around every rising edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      lcd_cs    <= 1'b1;
      lcd_sck   <= 1'b0;
      lcd_mosi  <= 1'b0;
      lcd_dc    <= DC_CMD;
      wr_done_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      wr_done_r <= 1'b0;
      busy_r    <= (state_d != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (bus.en_write) begin
            shreg    <= bus.data[7:0];
            lcd_dc   <= bus.data[8];
            lcd_cs   <= 1'b0;
            lcd_mosi <= bus.data[7];
            bit_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise || sck_fall) begin
            lcd_sck <= ~lcd_sck;
          end
          if (sck_fall) begin
            if (bit_cnt == BIT_LAST) begin
              wr_done_r <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              lcd_mosi <= shreg[6];
              shreg    <= {shreg[6:0], 1'b0};
            end
          end
        end
        ST_DONE: begin
          lcd_cs  <= 1'b1;
          lcd_sck <= 1'b0;
          gap_cnt <= '0;
        end
        ST_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          lcd_cs <= 1'b1;
        end
      endcase
    end
  end

endmodule
